parout_sched: RTL and testbench

Round-robin scheduler that shares the `parallel_out` peripheral between `N_REQ` byte producers. It sits between the producers and the SoC bus as a bus master. For each byte it does three things: writes the byte to the peripheral's DATA register, writes 1 to CONTROL to start output, then polls CONTROL until busy clears. Only then does it accept the next byte, so every byte reaches `parout` exactly once, in grant order.

---
 rtl/parout_sched_pkg.sv | 27 ++
 rtl/bus_if.sv | 14 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/parout_sched.sv | 188 ++++++++++++++++++
 tb/tb_parout_sched.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parout_sched_pkg.sv
// Shared types and constants for the parout_sched round-robin scheduler.
// Optional poll timeout is enabled by defining PAROUT_SCHED_TIMEOUT_EN.
package parout_sched_pkg;

  // Register offsets inside a parallel_out instance.
  localparam logic [31:0] PAROUT_CTRL_OFFS = 32'h0;
  localparam logic [31:0] PAROUT_DATA_OFFS = 32'h4;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    WR_CTRL,
    POLL
  } sched_state_e;

  // Phase of the single outstanding bus access.
  typedef enum logic {
    PH_REQ,
    PH_WAIT
  } bus_phase_e;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bus_if.sv
// Simple request/grant SoC bus: one access outstanding, response on rvalid.
interface bus_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (output req, we, addr, wdata, input gnt, rdata, rvalid, err);
  modport slave  (input req, we, addr, wdata, output gnt, rdata, rvalid, err);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid index at or after ptr_i wins.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Rotating priority search starting at the pointer.
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    // NOTE: every output gets a default before any branch, otherwise the
    // paths that skip an assignment would infer a latch.
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        j = int'(ptr_i) + k;
        if (j >= N) j = j - N;
        jj = j[IW-1:0];
        if (!any_o && valid_i[jj]) begin
          any_o     = 1'b1;
          idx_o     = jj;
          gnt_o[jj] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/parout_sched.sv
// parout_sched: shares one parallel_out peripheral between N_REQ byte
// producers. Per byte: write DATA, write CONTROL=1, poll CONTROL until idle.
// Define PAROUT_SCHED_TIMEOUT_EN to bound the number of CONTROL reads per
// byte to POLL_TIMEOUT; otherwise polling waits indefinitely.
module parout_sched
  import parout_sched_pkg::*;
#(
  parameter  int          N_REQ        = 4,
  parameter  logic [31:0] BASE_ADDR    = 32'h0,
  parameter  int          POLL_TIMEOUT = 64,
  localparam int          IW           = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  bus_if.master              bus,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*8-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               busy_o,
  output logic               sent_o,
  output logic [IW-1:0]      sent_id_o,
  output logic               err_o,
  input  logic               clear_i
);

  if (N_REQ < 2 || N_REQ > 8 || POLL_TIMEOUT < 1) begin : g_bad_cfg
    $error("parout_sched: N_REQ must be 2..8 and POLL_TIMEOUT >= 1");
  end

  sched_state_e state_q, state_d;
  bus_phase_e   phase_q, phase_d;

  logic [IW-1:0]    ptr_q, id_q, arb_idx;
  logic [N_REQ-1:0] arb_gnt;
  logic             arb_any;
  logic [7:0]       byte_q;
  logic             err_q, err_set;
  logic             grant, acc_done;
  logic             bus_req, bus_we;
  logic [31:0]      bus_addr, bus_wdata;
  logic             unused_rdata;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .en_i    (state_q == IDLE),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign grant        = (state_q == IDLE) && arb_any;
  assign acc_done     = (phase_q == PH_WAIT) && bus.rvalid;
  assign unused_rdata = ^bus.rdata[31:1];

  assign req_ready_o = arb_gnt;
  assign busy_o      = (state_q != IDLE);
  assign sent_id_o   = id_q;
  assign err_o       = err_q;

  assign bus.req   = bus_req;
  assign bus.we    = bus_we;
  assign bus.addr  = bus_addr;
  assign bus.wdata = bus_wdata;

`ifdef PAROUT_SCHED_TIMEOUT_EN
  localparam int PCW = $clog2(POLL_TIMEOUT + 1);

  logic [PCW-1:0] poll_cnt_q;
  logic           poll_clr, poll_inc, poll_last;

  assign poll_last = (poll_cnt_q == PCW'(POLL_TIMEOUT - 1));

  // Counts busy CONTROL reads of the current byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       poll_cnt_q <= '0;
    else if (poll_clr) poll_cnt_q <= '0;
    else if (poll_inc) poll_cnt_q <= poll_cnt_q + 1'b1;
  end
`endif

  // Next state, bus access phase and bus drive; addr/wdata follow the state
  // so they stay stable for the whole request phase.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = BASE_ADDR + PAROUT_CTRL_OFFS;
    bus_wdata = '0;
    sent_o    = 1'b0;
    err_set   = 1'b0;
`ifdef PAROUT_SCHED_TIMEOUT_EN
    poll_clr  = 1'b0;
    poll_inc  = 1'b0;
`endif

    if (state_q != IDLE) begin
      if (phase_q == PH_REQ) begin
        bus_req = 1'b1;
        if (bus.gnt) phase_d = PH_WAIT;
      end else if (bus.rvalid) begin
        phase_d = PH_REQ;
      end
    end

    case (state_q)
      IDLE: begin
        if (arb_any) state_d = WR_DATA;
      end
      WR_DATA: begin
        bus_we    = 1'b1;
        bus_addr  = BASE_ADDR + PAROUT_DATA_OFFS;
        bus_wdata = {24'h0, byte_q};
        if (acc_done) state_d = WR_CTRL;
      end
      WR_CTRL: begin
        bus_we    = 1'b1;
        bus_wdata = 32'h1;
        if (acc_done) begin
          state_d = POLL;
`ifdef PAROUT_SCHED_TIMEOUT_EN
          poll_clr = 1'b1;
`endif
        end
      end
      POLL: begin
        if (acc_done && !bus.err) begin
          if (!bus.rdata[0]) begin
            sent_o  = 1'b1;
            state_d = IDLE;
          end
`ifdef PAROUT_SCHED_TIMEOUT_EN
          else if (poll_last) begin
            err_set = 1'b1;
            state_d = IDLE;
          end else begin
            poll_inc = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // A bus error on any access drops the byte.
    if (acc_done && bus.err) begin
      err_set = 1'b1;
      state_d = IDLE;
    end
  end

  // FSM and bus phase registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of block ordering.
    if (!rst_ni) begin
      state_q <= IDLE;
      phase_q <= PH_REQ;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Grant bookkeeping: byte, requester index and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: byte_q is plain datapath, but it is reset so nothing undefined
    // can ever appear on wdata; id_q must reset because it drives sent_id_o.
    if (!rst_ni) begin
      ptr_q  <= '0;
      id_q   <= '0;
      byte_q <= '0;
    end else if (grant) begin
      ptr_q  <= IW'(wrap_inc(32'(arb_idx), N_REQ));
      id_q   <= arb_idx;
      byte_q <= req_data_i[{arb_idx, 3'b000} +: 8];
    end
  end

  // Sticky error flag; a new error wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
    else if (clear_i) err_q <= 1'b0;
  end

endmodule

// File: tb/tb_parout_sched.sv
// Self-checking bench for parout_sched with a behavioural parallel_out slave.
// Honors PAROUT_SCHED_TIMEOUT_EN the same way the design does.
module tb_parout_sched;

  localparam int          N      = 4;
  localparam int          TO     = 4;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_DATA = BASE + 32'h4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  bus_if bus ();

  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           busy, sent, err;
  logic           clear = 1'b0;
  logic [1:0]     sent_id;

  parout_sched #(.N_REQ(N), .BASE_ADDR(BASE), .POLL_TIMEOUT(TO)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .busy_o      (busy),
    .sent_o      (sent),
    .sent_id_o   (sent_id),
    .err_o       (err),
    .clear_i     (clear)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- parallel_out slave model ----------------
  int         gnt_delay = 0;
  int         busy_len  = 3;
  bit         stuck     = 1'b0;
  bit         inj_err   = 1'b0;
  int         wait_cnt;
  int         pbusy;
  int         n_reads   = 0;
  logic [7:0] pdata;
  logic       parout_valid;
  logic [7:0] parout;

  assign bus.gnt = bus.req && (wait_cnt >= gnt_delay);

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.rvalid   <= 1'b0;
      bus.err      <= 1'b0;
      bus.rdata    <= '0;
      wait_cnt     <= 0;
      pbusy        <= 0;
      pdata        <= '0;
      parout_valid <= 1'b0;
      parout       <= '0;
    end else begin
      bus.rvalid   <= 1'b0;
      bus.err      <= 1'b0;
      parout_valid <= 1'b0;
      if (pbusy > 0) pbusy <= pbusy - 1;
      if (bus.req && bus.gnt) begin
        wait_cnt   <= 0;
        bus.rvalid <= 1'b1;
        if (bus.we && bus.addr == A_DATA) begin
          pdata <= bus.wdata[7:0];
        end else if (bus.we && bus.addr == A_CTRL) begin
          if (inj_err) begin
            bus.err <= 1'b1;
          end else if (bus.wdata[0]) begin
            parout_valid <= 1'b1;
            parout       <= pdata;
            pbusy        <= busy_len;
          end
        end else if (!bus.we && bus.addr == A_CTRL) begin
          n_reads   <= n_reads + 1;
          bus.rdata <= {31'b0, (stuck || pbusy > 0)};
        end else begin
          bus.err <= 1'b1;
        end
      end else if (bus.req) begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // ---------------- reference model and compare process ----------------
  int         m_ptr, m_acc, m_polls, m_id;
  bit         m_busy, m_err, m_first;
  logic [7:0] m_byte;
  logic [N-1:0] exp_oh;
  bit         busy_nx, err_ev, exp_sent;
  int         j;
  logic       p_req, p_gnt, p_we;
  logic [31:0] p_addr, p_wdata;
  int         n_sent = 0;
  int         grant_log[$];
  int         sent_log[$];
  logic [7:0] parout_log[$];

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_ptr = 0; m_acc = 0; m_polls = 0; m_id = 0; m_byte = '0;
      m_busy = 0; m_err = 0; m_first = 0;
      p_req = 0; p_gnt = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    end else begin
      busy_nx  = m_busy;
      err_ev   = 0;
      exp_sent = 0;
      check("busy_o", busy, m_busy);
      check("err_o", err, m_err);

      if (p_req && !p_gnt) begin
        check("req_held", bus.req, 1);
        check("addr_held", bus.addr, p_addr);
        check("we_held", bus.we, p_we);
        check("wdata_held", bus.wdata, p_wdata);
      end
      if (p_req && p_gnt) check("req_drop", bus.req, 0);
      if (m_first) begin
        check("first_req", bus.req, 1);
        check("first_addr", bus.addr, A_DATA);
        m_first = 0;
      end

      exp_oh = '0;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (req_valid[j] && exp_oh == '0) exp_oh[j] = 1'b1;
        end
      end
      check("req_ready", req_ready, exp_oh);
      for (int k = 0; k < N; k++) if (req_ready[k]) grant_log.push_back(k);
      for (int k = 0; k < N; k++) begin
        if (exp_oh[k]) begin
          m_id    = k;
          m_byte  = req_data[k*8 +: 8];
          m_ptr   = (k + 1) % N;
          m_acc   = 0;
          m_polls = 0;
          m_first = 1;
          busy_nx = 1;
        end
      end

      if (bus.req && bus.gnt) begin
        if (m_acc == 0) begin
          check("data_we", bus.we, 1);
          check("data_addr", bus.addr, A_DATA);
          check("data_wdata", bus.wdata, {24'h0, m_byte});
        end else if (m_acc == 1) begin
          check("ctrl_we", bus.we, 1);
          check("ctrl_addr", bus.addr, A_CTRL);
          check("ctrl_wdata", bus.wdata, 32'h1);
        end else begin
          check("poll_we", bus.we, 0);
          check("poll_addr", bus.addr, A_CTRL);
        end
        m_acc++;
      end

      if (parout_valid) begin
        parout_log.push_back(parout);
        check("parout", parout, m_byte);
      end

      if (bus.rvalid) begin
        if (bus.err) err_ev = 1;
        else if (m_acc >= 3) begin
          if (!bus.rdata[0]) exp_sent = 1;
          else begin
            m_polls++;
`ifdef PAROUT_SCHED_TIMEOUT_EN
            if (m_polls == TO) err_ev = 1;
`endif
          end
        end
      end

      check("sent_o", sent, exp_sent);
      if (sent) begin
        sent_log.push_back(sent_id);
        n_sent++;
        check("sent_id", sent_id, m_id);
      end
      if (exp_sent || err_ev) busy_nx = 0;
      m_err  = err_ev ? 1'b1 : (clear ? 1'b0 : m_err);
      m_busy = busy_nx;
      p_req = bus.req; p_gnt = bus.gnt; p_we = bus.we; p_addr = bus.addr; p_wdata = bus.wdata;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_one(input int idx, input logic [7:0] b);
    int c;
    c = 0;
    req_data[idx*8 +: 8] = b;
    req_valid[idx] = 1'b1;
    do begin
      @(negedge clk_i);
      c++;
    end while (!req_ready[idx] && c < 300);
    check("grant_wait", req_ready[idx], 1);
    @(posedge clk_i); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_sent(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (n_sent < target && c < budget) begin
      @(posedge clk_i);
      c++;
    end
    #1;
    check(name, (n_sent >= target), 1);
  endtask

  task automatic wait_err(input int budget, input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk_i);
      c++;
    end while (!err && c < budget);
    check(name, err, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int g0, s0, n0, rd0;
    int   exp_g[8];
    logic [7:0] exp_b[8];
    exp_g = '{3, 0, 1, 2, 3, 0, 1, 2};
    exp_b = '{8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33};

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_busy", busy, 0);
    check("rst_sent", sent, 0);
    check("rst_ready", req_ready, 0);
    check("rst_err", err, 0);
    check("rst_sent_id", sent_id, 0);
    check("rst_bus_req", bus.req, 0);
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i); #1;

    // Single byte from requester 2.
    send_one(2, 8'hA5);
    wait_sent(1, 200, "single_done");
    check("single_parout", parout_log[parout_log.size()-1], 8'hA5);
    check("single_id", sent_log[sent_log.size()-1], 2);
    @(negedge clk_i);
    check("single_busy_low", busy, 0);

    // Fairness: all requesters continuously valid; pointer starts at 3.
    g0 = grant_log.size();
    s0 = parout_log.size();
    @(posedge clk_i); #1;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    wait_sent(n_sent + 8, 400, "fair_done");
    req_valid = '0;
    for (int i = 0; i < 8; i++) begin
      check("fair_grant", grant_log[g0+i], exp_g[i]);
      check("fair_parout", parout_log[s0+i], exp_b[i]);
    end

    // Bus stall: every grant delayed 5 cycles.
    gnt_delay = 5;
    send_one(0, 8'h5C);
    wait_sent(n_sent + 1, 300, "stall_done");
    check("stall_id", sent_log[sent_log.size()-1], 0);
    check("stall_parout", parout_log[parout_log.size()-1], 8'h5C);
    gnt_delay = 0;

    // Error on the CONTROL write: sticky flag, no sent, clear, then recover.
    n0 = n_sent;
    inj_err = 1'b1;
    send_one(1, 8'h77);
    wait_err(100, "err_seen");
    repeat (4) begin
      @(negedge clk_i);
      check("err_sticky", err, 1);
    end
    check("err_idle", busy, 0);
    check("err_no_sent", n_sent, n0);
    inj_err = 1'b0;
    @(posedge clk_i); #1; clear = 1'b1;
    @(posedge clk_i); #1; clear = 1'b0;
    @(negedge clk_i);
    check("err_cleared", err, 0);
    send_one(1, 8'h78);
    wait_sent(n0 + 1, 200, "after_err_done");
    check("after_err_id", sent_log[sent_log.size()-1], 1);
    check("after_err_parout", parout_log[parout_log.size()-1], 8'h78);

    // Error while clear_i is held: the error must still register for a cycle.
    @(posedge clk_i); #1;
    clear   = 1'b1;
    inj_err = 1'b1;
    send_one(3, 8'h99);
    wait_err(100, "err_wins");
    @(negedge clk_i);
    check("err_then_cleared", err, 0);
    @(posedge clk_i); #1;
    clear   = 1'b0;
    inj_err = 1'b0;

    // Peripheral stuck busy.
    stuck = 1'b1;
    rd0   = n_reads;
    send_one(2, 8'hEE);
`ifdef PAROUT_SCHED_TIMEOUT_EN
    wait_err(200, "timeout_err");
    repeat (3) @(negedge clk_i);
    check("timeout_reads", n_reads - rd0, TO);
    check("timeout_idle", busy, 0);
    @(posedge clk_i); #1; clear = 1'b1;
    @(posedge clk_i); #1; clear = 1'b0;
    rd0 = n_reads;
    send_one(1, 8'h3C);
    begin
      int c;
      c = 0;
      while (n_reads - rd0 < 2 && c < 100) begin
        @(negedge clk_i);
        c++;
      end
    end
    check("poll_started", (n_reads - rd0 >= 2), 1);
`else
    repeat (60) @(negedge clk_i);
    check("nto_err", err, 0);
    check("nto_busy", busy, 1);
    check("nto_reads", (n_reads - rd0 >= 20), 1);
`endif

    // Reset in the middle of polling: asynchronous return to reset values.
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_sent", sent, 0);
    check("arst_ready", req_ready, 0);
    check("arst_err", err, 0);
    check("arst_sent_id", sent_id, 0);
    check("arst_bus_req", bus.req, 0);
    stuck = 1'b0;
    repeat (3) @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    g0 = grant_log.size();
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req_valid = 4'b1101;
    wait_sent(n_sent + 3, 300, "post_rst_done");
    req_valid = '0;
    check("post_rst_g0", grant_log[g0], 0);
    check("post_rst_g1", grant_log[g0+1], 2);
    check("post_rst_g2", grant_log[g0+2], 3);
    check("post_rst_parout", parout_log[parout_log.size()-1], 8'hD3);

    repeat (5) @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
